// File: rtl/conv_decoder_processing_element_array.sv
// Transposed-convolution PE array: each accepted pixel is scaled by every kernel tap
// and scattered into a shifting bank of partial sums; flush drains the tail.
module conv_decoder_processing_element_array #(
   parameter int KERNEL = 14,
   parameter int DATA_W = 18,
   parameter int FRAC   = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       flush,
   input  logic [DATA_W-1:0]          x,
   input  logic [KERNEL*DATA_W-1:0]   w,
   output logic [DATA_W-1:0]          output_pixel,
   output logic                       ready,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned ACC_W  = PROD_W + 4;
   localparam int unsigned NACC   = KERNEL - 1;
   localparam int unsigned CNT_W  = $clog2(KERNEL);

   typedef enum logic {ACC, DRAIN} state_t;

   state_t                    state, state_next;
   logic                      accept, drain_emit, drain_last;
   logic signed [PROD_W-1:0]  p [KERNEL];
   logic                      p_valid;
   logic signed [ACC_W-1:0]   acc [NACC];
   logic signed [ACC_W-1:0]   s;
   logic                      s_valid;
   logic signed [ACC_W-1:0]   emit_val;
   logic                      flush_pend;
   logic [CNT_W-1:0]          cnt;
   logic                      done_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_next;
   end

   // Drain only once the last product has been folded in, so tail readys abut the frame readys.
   always_comb begin
      state_next = state;
      case (state)
         ACC:     if (flush_pend && !p_valid && !start) state_next = DRAIN;
         DRAIN:   if (cnt == CNT_W'(NACC - 1)) state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   always_comb begin
      accept     = (state == ACC) && start;
      drain_emit = (state == DRAIN);
      drain_last = drain_emit && (cnt == CNT_W'(NACC - 1));
      emit_val   = drain_emit ? acc[0] : s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < KERNEL; k++) p[k] <= '0;
         for (int unsigned k = 0; k < NACC; k++) acc[k] <= '0;
         p_valid      <= 1'b0;
         s            <= '0;
         s_valid      <= 1'b0;
         flush_pend   <= 1'b0;
         cnt          <= '0;
         done_pend    <= 1'b0;
         output_pixel <= '0;
         ready        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         p_valid <= accept;
         if (accept)
            for (int unsigned k = 0; k < KERNEL; k++)
               p[k] <= $signed(x) * $signed(w[k*DATA_W +: DATA_W]);

         s_valid <= p_valid;
         if (p_valid) begin
            s <= acc[0] + ACC_W'(p[0]);
            for (int unsigned k = 0; k < NACC - 1; k++)
               acc[k] <= acc[k+1] + ACC_W'(p[k+1]);
            acc[NACC-1] <= ACC_W'(p[KERNEL-1]);
         end else if (drain_emit) begin
            for (int unsigned k = 0; k < NACC - 1; k++)
               acc[k] <= acc[k+1];
            acc[NACC-1] <= '0;
         end

         cnt <= drain_emit ? cnt + 1'b1 : '0;

         if (drain_last)                  flush_pend <= 1'b0;
         else if (state == ACC && flush)  flush_pend <= 1'b1;

         // Frame sums come from s (one extra register); tail sums skip it and go straight out.
         ready <= s_valid | drain_emit;
         if (s_valid | drain_emit)
            output_pixel <= DATA_W'(emit_val >>> FRAC);
         busy      <= drain_emit;
         done_pend <= drain_last;
         done      <= done_pend;
      end
   end

endmodule
